playlist_ctrl: RTL and testbench
================================

Name: playlist_ctrl

Overview:
- User-facing controller that drives the song player's `index`, `pause` and per-song reset.
- Turns raw buttons (play/pause, next, prev, mode) into debounced press events.
- Tracks the current song among the available slots and reacts to the player's end-of-song `over` level.
- Sits between the board pushbuttons and the player, as the initiator of the index/pause/over interface.

Parameters:
- `VALID_MASK`, 8'b0000_1101: bit i set means song index i exists in the player; must be nonzero.
- `DEB_CYC`, 20'd500000: number of stable cycles required before a button level is accepted.
- `RST_CYC`, 4'd4: number of cycles `player_rst_n` is held low on every song (re)start.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `btn_play`  in  1  raw play/pause button, active-high, asynchronous
- `btn_next`  in  1  raw next-song button, active-high
- `btn_prev`  in  1  raw previous-song button, active-high
- `btn_mode`  in  1  raw mode-cycle button, active-high
- `song_over`  in  1  player end-of-song level, high while the current song has finished
- `index`  out  8  selected song number, always a set bit position of `VALID_MASK`
- `pause`  out  1  1 = player paused
- `player_rst_n`  out  1  active-low restart for the player; low restarts the current song
- `playing`  out  1  1 in PLAY state (LED)
- `mode`  out  2  0 = SEQ (advance, wrap), 1 = REPEAT_ONE, 2 = STOP_AT_END; 3 is never produced

Behaviour:
- Reset (async, `rst_n` = 0):
  - Internal values: state = IDLE.
  - Output values: `index` = lowest set bit of `VALID_MASK`, `pause` = 1, `player_rst_n` = 0, `playing` = 0, `mode` = 0.
  - Debouncers cleared to "released".
- Button path, per button:
  - 2-FF synchroniser, then a counter that loads 0 on any change of the synchronised level.
  - The accepted level updates after `DEB_CYC` consecutive equal samples.
  - A press event is a one-cycle pulse on an accepted 0→1 transition.
  - Latency from a clean edge to the event: 2 + `DEB_CYC` + 1 cycles.
  - Holding a button produces exactly one event.
- `over_rise` = `song_over` registered-edge (0→1) detector; it is evaluated only in PLAY.
- States and transitions:
  - IDLE: `pause` = 1, `player_rst_n` = 0.
    - play → SWITCH (target PLAY).
    - next/prev move `index`; the state stays IDLE.
  - SWITCH: `player_rst_n` = 0, `pause` = 1 for exactly `RST_CYC` cycles.
    - Then go to the latched target (PLAY or PAUSED).
    - All button events and `over_rise` are dropped while in SWITCH.
  - PLAY: `pause` = 0, `player_rst_n` = 1, `playing` = 1.
    - play → PAUSED.
    - next/prev → update `index`, then SWITCH (target PLAY).
    - `over_rise` with mode SEQ → next valid index with wrap, SWITCH (PLAY).
    - `over_rise` with mode REPEAT_ONE → same index, SWITCH (PLAY).
    - `over_rise` with mode STOP_AT_END at the highest valid index → IDLE; otherwise behave as SEQ.
  - PAUSED: `pause` = 1, `player_rst_n` = 1 (song position kept).
    - play → PLAY.
    - next/prev → update `index`, SWITCH (target PAUSED).
    - `song_over` is ignored.
- Index arithmetic:
  - next = the smallest set bit of `VALID_MASK` above `index`, else the lowest set bit (wrap).
  - prev = the largest set bit below `index`, else the highest set bit (wrap).
  - Computed combinationally over 8 bits; `index` is updated registered, in the same cycle as the state change.
  - With a single valid bit, next/prev leave `index` unchanged but still cause SWITCH (restart).
- Simultaneous events:
  - next and prev in the same cycle → both ignored.
  - play together with next/prev → next/prev wins and play is dropped.
  - `over_rise` together with any button in PLAY → the button wins.
- mode event: cycles 0→1→2→0. It is accepted in every state including SWITCH, and applies from the next `over_rise`.
- Reset mid-SWITCH or mid-debounce: async return to the reset values; no partial restart pulse continues.

Decomposition:
- Package `player_pkg`:
  - state enum {IDLE, SWITCH, PLAY, PAUSED}.
  - mode encodings MODE_SEQ = 2'd0, MODE_REPEAT = 2'd1, MODE_STOP = 2'd2.
  - functions `first_valid`, `last_valid`, `next_valid`, `prev_valid` over an 8-bit mask.
- Sub-module `btn_debounce`:
  - Contains the synchroniser, counter and edge pulse, parameterised by `DEB_CYC`.
  - Instantiated 4 times.

Test Plan:
Common bench settings: `DEB_CYC` = 4, `RST_CYC` = 2, `VALID_MASK` = 8'h0D.
1. Reset release, then a play press held 10 cycles → one event. `player_rst_n` is low for 2 cycles, then `pause` = 0, `playing` = 1, `index` = 0.
2. In PLAY press next three times → `index` goes 0→2→3→0. Each press gives a 2-cycle `player_rst_n` low pulse.
3. PLAY at `index` 3, mode SEQ, `song_over` 0→1 → `index` = 0 and a restart pulse. With mode STOP_AT_END → IDLE, `pause` = 1, `index` stays 3.
4. A 2-cycle glitch on `btn_next` → no event and `index` unchanged. next and prev pressed together → `index` unchanged.
5. PAUSED at `index` 2, prev press → `index` = 0, SWITCH then PAUSED (`pause` remains 1). `song_over` pulse while paused → no change.
6. Assert `rst_n` = 0 during the SWITCH low pulse → immediate reset values. After release the state is IDLE with `index` = 0.

Source files
------------

// File: rtl/player_pkg.sv
// Shared types, mode encodings and index helpers for the playlist controller.
package player_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SWITCH,
      PLAY,
      PAUSED
   } state_e;

   localparam logic [1:0] MODE_SEQ    = 2'd0;
   localparam logic [1:0] MODE_REPEAT = 2'd1;
   localparam logic [1:0] MODE_STOP   = 2'd2;

   // Lowest set bit of the mask.
   function automatic logic [7:0] first_valid(input logic [7:0] mask);
      logic [7:0] r;
      r = 8'd0;
      for (int i = 7; i >= 0; i--) begin
         if (mask[i]) r = 8'(i);
      end
      return r;
   endfunction

   // Highest set bit of the mask.
   function automatic logic [7:0] last_valid(input logic [7:0] mask);
      logic [7:0] r;
      r = 8'd0;
      for (int i = 0; i < 8; i++) begin
         if (mask[i]) r = 8'(i);
      end
      return r;
   endfunction

   // Smallest set bit above idx, wrapping to the lowest set bit.
   function automatic logic [7:0] next_valid(input logic [7:0] mask, input logic [7:0] idx);
      logic [7:0] r;
      r = first_valid(mask);
      for (int i = 7; i >= 0; i--) begin
         if (mask[i] && (8'(i) > idx)) r = 8'(i);
      end
      return r;
   endfunction

   // Largest set bit below idx, wrapping to the highest set bit.
   function automatic logic [7:0] prev_valid(input logic [7:0] mask, input logic [7:0] idx);
      logic [7:0] r;
      r = last_valid(mask);
      for (int i = 0; i < 8; i++) begin
         if (mask[i] && (8'(i) < idx)) r = 8'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/playlist_ctrl_if.sv
// Controller-to-player link: song select, pause, restart and end-of-song level.
interface playlist_ctrl_if;
   logic [7:0] index;
   logic       pause;
   logic       player_rst_n;
   logic       song_over;

   modport master (output index, output pause, output player_rst_n, input song_over);
   modport slave  (input index, input pause, input player_rst_n, output song_over);
endinterface

// File: rtl/btn_debounce.sv
// Raw pushbutton to one-cycle press pulse: 2-FF synchroniser, stability counter, rise detect.
module btn_debounce #(
   parameter int unsigned DEB_CYC = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic press_o
);

   localparam int unsigned CntW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYC - 1);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d, level_old_q, press_q;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Counter restarts whenever the synchronised level agrees with the accepted one,
   // so only DEB_CYC consecutive differing samples flip the accepted level.
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CntLast) begin
         level_d = sync2_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Synchroniser, debounce state and registered rise pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         level_q     <= 1'b0;
         level_old_q <= 1'b0;
         press_q     <= 1'b0;
         cnt_q       <= '0;
      end else begin
         sync1_q     <= btn_i;
         sync2_q     <= sync1_q;
         level_q     <= level_d;
         level_old_q <= level_q;
         press_q     <= level_q & ~level_old_q;
         cnt_q       <= cnt_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/playlist_ctrl.sv
// Playlist controller: debounced buttons drive song index, pause and restart pulses.
module playlist_ctrl
   import player_pkg::*;
#(
   parameter logic [7:0]  VALID_MASK = 8'b0000_1101,
   parameter int unsigned DEB_CYC    = 500000,
   parameter int unsigned RST_CYC    = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   btn_play,
   input  logic                   btn_next,
   input  logic                   btn_prev,
   input  logic                   btn_mode,
   playlist_ctrl_if.master        bus,
   output logic                   playing,
   output logic [1:0]             mode
);

   localparam int unsigned RcW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [RcW-1:0] RcLast = RcW'(RST_CYC - 1);

   logic ev_play, ev_next, ev_prev, ev_mode;
   logic over_q, over_rise, move, any_btn;
   logic [7:0] move_idx;

   state_e         state_q, state_d, target_q, target_d;
   logic [7:0]     index_q, index_d;
   logic [1:0]     mode_q, mode_d;
   logic [RcW-1:0] rst_cnt_q, rst_cnt_d;

   btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_play (
      .clk(clk), .rst_n(rst_n), .btn_i(btn_play), .press_o(ev_play));
   btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_next (
      .clk(clk), .rst_n(rst_n), .btn_i(btn_next), .press_o(ev_next));
   btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_prev (
      .clk(clk), .rst_n(rst_n), .btn_i(btn_prev), .press_o(ev_prev));
   btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (
      .clk(clk), .rst_n(rst_n), .btn_i(btn_mode), .press_o(ev_mode));

   assign over_rise = bus.song_over & ~over_q;
   // next together with prev cancels both
   assign move      = ev_next ^ ev_prev;
   assign any_btn   = ev_play | ev_next | ev_prev | ev_mode;
   assign move_idx  = ev_next ? next_valid(VALID_MASK, index_q) : prev_valid(VALID_MASK, index_q);

   // Next-state, index and mode update.
   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      index_d   = index_q;
      mode_d    = mode_q;
      rst_cnt_d = rst_cnt_q;

      if (ev_mode) mode_d = (mode_q == MODE_STOP) ? MODE_SEQ : mode_q + 2'd1;

      case (state_q)
         IDLE: begin
            if (move) begin
               index_d = move_idx;
            end else if (ev_play && !ev_next && !ev_prev) begin
               state_d   = SWITCH;
               target_d  = PLAY;
               rst_cnt_d = '0;
            end
         end
         SWITCH: begin
            if (rst_cnt_q == RcLast) state_d = target_q;
            else rst_cnt_d = rst_cnt_q + RcW'(1);
         end
         PLAY: begin
            if (move) begin
               index_d   = move_idx;
               state_d   = SWITCH;
               target_d  = PLAY;
               rst_cnt_d = '0;
            end else if (ev_play && !ev_next && !ev_prev) begin
               state_d = PAUSED;
            end else if (over_rise && !any_btn) begin
               if (mode_q == MODE_STOP && index_q == last_valid(VALID_MASK)) begin
                  state_d = IDLE;
               end else begin
                  if (mode_q != MODE_REPEAT) index_d = next_valid(VALID_MASK, index_q);
                  state_d   = SWITCH;
                  target_d  = PLAY;
                  rst_cnt_d = '0;
               end
            end
         end
         PAUSED: begin
            if (move) begin
               index_d   = move_idx;
               state_d   = SWITCH;
               target_d  = PAUSED;
               rst_cnt_d = '0;
            end else if (ev_play && !ev_next && !ev_prev) begin
               state_d = PLAY;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Controller state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         target_q  <= PLAY;
         index_q   <= first_valid(VALID_MASK);
         mode_q    <= MODE_SEQ;
         rst_cnt_q <= '0;
         over_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         index_q   <= index_d;
         mode_q    <= mode_d;
         rst_cnt_q <= rst_cnt_d;
         over_q    <= bus.song_over;
      end
   end

   assign bus.index        = index_q;
   assign bus.pause        = (state_q != PLAY);
   assign bus.player_rst_n = (state_q == PLAY) || (state_q == PAUSED);
   assign playing          = (state_q == PLAY);
   assign mode             = mode_q;

endmodule

// File: tb/tb_playlist_ctrl.sv
// Bench for playlist_ctrl: directed scenarios plus random button/over operations
// checked against a list-based model of the playlist.
module tb_playlist_ctrl;

   localparam int         DEB  = 4;
   localparam int         RSTC = 2;
   localparam logic [7:0] MASK = 8'h0D;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_play = 1'b0, btn_next = 1'b0, btn_prev = 1'b0, btn_mode = 1'b0;
   logic       playing;
   logic [1:0] mode;

   playlist_ctrl_if pif();

   playlist_ctrl #(.VALID_MASK(MASK), .DEB_CYC(DEB), .RST_CYC(RSTC)) dut (
      .clk(clk), .rst_n(rst_n), .btn_play(btn_play), .btn_next(btn_next),
      .btn_prev(btn_prev), .btn_mode(btn_mode), .bus(pif.master),
      .playing(playing), .mode(mode));

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model: playlist as an ordered list of valid songs, position into it.
   int vlist[$];
   int m_pos, m_state, m_mode;  // m_state: 0 idle, 1 play, 2 paused
   bit m_sw;
   int lows, pz;

   function automatic void model_reset();
      m_pos = 0; m_state = 0; m_mode = 0;
   endfunction

   function automatic void model_step(input bit p, input bit n, input bit pv, input bit md,
                                      input bit ov);
      int cnt;
      bit mv;
      cnt  = vlist.size();
      m_sw = 0;
      mv   = n != pv;
      if (md) m_mode = (m_mode + 1) % 3;
      if (mv && n) m_pos = (m_pos + 1) % cnt;
      else if (mv) m_pos = (m_pos + cnt - 1) % cnt;
      case (m_state)
         0: if (!mv && p && !n && !pv) m_state = 1;
         1: begin
            if (mv) m_sw = 1;
            else if (p && !n && !pv) m_state = 2;
            else if (ov && !md) begin
               if (m_mode == 2 && m_pos == cnt - 1) m_state = 0;
               else begin
                  if (m_mode != 1) m_pos = (m_pos + 1) % cnt;
                  m_sw = 1;
               end
            end
         end
         default: begin
            if (mv) m_sw = 1;
            else if (p && !n && !pv) m_state = 1;
         end
      endcase
   endfunction

   task automatic check_outputs(input string tag);
      check_eq({tag, "/index"}, 32'(pif.index), 32'(vlist[m_pos]));
      check_eq({tag, "/pause"}, 32'(pif.pause), 32'(m_state != 1));
      check_eq({tag, "/playing"}, 32'(playing), 32'(m_state == 1));
      check_eq({tag, "/player_rst_n"}, 32'(pif.player_rst_n), 32'(m_state != 0));
      check_eq({tag, "/mode"}, 32'(mode), 32'(m_mode));
   endtask

   task automatic sample();
      @(negedge clk);
      if (pif.player_rst_n === 1'b0) lows++;
      if (pif.pause === 1'b0) pz++;
   endtask

   // ops: 0 play, 1 next, 2 prev, 3 mode, 4 over, 5 next+prev, 6 glitch next, 7 play+next
   task automatic do_op(input int op, input string tag);
      bit p, n, pv, md, ov, gl;
      int hold, prev_st;
      p  = (op == 0) || (op == 7);
      n  = (op == 1) || (op == 5) || (op == 7) || (op == 6);
      pv = (op == 2) || (op == 5);
      md = (op == 3);
      ov = (op == 4);
      gl = (op == 6);
      hold = gl ? 2 : (ov ? 3 : DEB + 6);
      lows = 0; pz = 0;
      btn_play = p; btn_next = n; btn_prev = pv; btn_mode = md; pif.song_over = ov;
      for (int i = 0; i < hold; i++) sample();
      btn_play = 0; btn_next = 0; btn_prev = 0; btn_mode = 0; pif.song_over = 0;
      for (int i = 0; i < DEB + 10; i++) sample();
      prev_st = m_state;
      if (gl) model_step(0, 0, 0, 0, 0);
      else model_step(p, n, pv, md, ov);
      check_outputs(tag);
      if (prev_st != 0 && m_state != 0) check_eq({tag, "/rst_pulse"}, lows, m_sw ? RSTC : 0);
      if (prev_st == 2 && m_state == 2) check_eq({tag, "/pause_held"}, pz, 0);
   endtask

   initial begin
      int w;
      for (int i = 0; i < 8; i++) if (MASK[i]) vlist.push_back(i);
      pif.song_over = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: play from idle
      do_op(0, "t1_play");
      check_eq("t1_idx0", 32'(pif.index), 32'd0);
      // 2: next x3 wraps 0->2->3->0
      do_op(1, "t2_n1"); check_eq("t2_idx2", 32'(pif.index), 32'd2);
      do_op(1, "t2_n2"); check_eq("t2_idx3", 32'(pif.index), 32'd3);
      do_op(1, "t2_n3"); check_eq("t2_idx0", 32'(pif.index), 32'd0);
      // 3: over at last song in SEQ wraps; in STOP goes idle
      do_op(1, "t3_a"); do_op(1, "t3_b");
      do_op(4, "t3_seq"); check_eq("t3_seq_idx", 32'(pif.index), 32'd0);
      do_op(1, "t3_c"); do_op(1, "t3_d");
      do_op(3, "t3_m1"); do_op(3, "t3_m2");
      do_op(4, "t3_stop"); check_eq("t3_stop_idx", 32'(pif.index), 32'd3);
      // 4: glitch and simultaneous next/prev
      do_op(6, "t4_glitch");
      do_op(5, "t4_both");
      // 5: paused prev presses, over ignored
      do_op(0, "t5_play"); do_op(0, "t5_pause");
      do_op(2, "t5_p1"); check_eq("t5_idx2", 32'(pif.index), 32'd2);
      do_op(2, "t5_p2"); check_eq("t5_idx0", 32'(pif.index), 32'd0);
      do_op(4, "t5_over");
      do_op(3, "t5_mode");

      // 6: reset during the restart pulse
      do_op(0, "t6_play");
      btn_next = 1'b1;
      w = 0;
      while (pif.player_rst_n !== 1'b0 && w < 40) begin
         @(negedge clk);
         w++;
      end
      check_eq("t6_saw_switch", 32'(w < 40), 32'd1);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("t6_in_reset");
      btn_next = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (DEB + 8) @(negedge clk);
      check_outputs("t6_after");

      // random operations
      for (int k = 0; k < 60; k++) do_op(int'($urandom_range(0, 7)), "rnd");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
